// File: rtl/fsm_cmd_feeder_if.sv
// ============================================================================
// Module   : fsm_cmd_feeder_if
// Brief    : Command producer / state-machine side bundle for fsm_cmd_feeder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fsm_cmd_feeder_if #(
    parameter int DEPTH = 4
);
    logic                     cmd_valid;
    logic [1:0]               cmd_data;
    logic                     cmd_ready;
    logic                     flush;
    logic [1:0]               fsm_in;
    logic                     fsm_cmd_strobe;
    logic                     busy;
    logic [$clog2(DEPTH):0]   count;

    // Producer / observer side.
    modport master (
        output cmd_valid,
        output cmd_data,
        output flush,
        input  cmd_ready,
        input  fsm_in,
        input  fsm_cmd_strobe,
        input  busy,
        input  count
    );

    // Feeder side.
    modport slave (
        input  cmd_valid,
        input  cmd_data,
        input  flush,
        output cmd_ready,
        output fsm_in,
        output fsm_cmd_strobe,
        output busy,
        output count
    );
endinterface

`default_nettype wire

// File: rtl/fsm_cmd_feeder.sv
// ============================================================================
// Module   : fsm_cmd_feeder
// Brief    : FIFO-buffered command presenter; holds each 2-bit command on
//            fsm_in for HOLD_CYCLES cycles, idle code otherwise.
//            Optional drop counter: define FSM_CMD_FEEDER_DROP_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_cmd_feeder #(
    parameter int         DEPTH       = 4,
    parameter int         HOLD_CYCLES = 1,
    parameter logic [1:0] IDLE_CODE   = 2'h3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fsm_cmd_feeder_if.slave    bus
`ifdef FSM_CMD_FEEDER_DROP_CNT_EN
    ,
    output logic [7:0]         drop_count
`endif
);

    localparam int c_ptr_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w  = $clog2(DEPTH) + 1;
    localparam int c_hold_w = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(DEPTH);
    localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_hold_w-1:0]  r_hold_cnt;
    logic [c_hold_w-1:0]  w_hold_nxt;
    logic [1:0]           r_fsm_in;
    logic [1:0]           w_fsm_in_nxt;
    logic                 r_strobe;
    logic                 w_strobe_nxt;
    logic                 w_ready;
    logic                 w_not_empty;
    logic                 w_push;
    logic                 w_pop;

    // Ready depends on occupancy alone, so a same-cycle pop never frees a slot.
    assign w_ready     = (r_count != c_depth);
    assign w_not_empty = (r_count != '0);
    assign w_push      = bus.cmd_valid && w_ready && !bus.flush;

    assign bus.cmd_ready      = w_ready;
    assign bus.fsm_in         = r_fsm_in;
    assign bus.fsm_cmd_strobe = r_strobe;
    assign bus.count          = r_count;
    assign bus.busy           = (r_state == ST_HOLD) || w_not_empty;

    // Presentation state machine: next state and presented code.
    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold_cnt;
        w_fsm_in_nxt = r_fsm_in;
        w_strobe_nxt = 1'b0;
        w_pop        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_fsm_in_nxt = IDLE_CODE;
                if (w_not_empty) begin
                    w_pop        = 1'b1;
                    w_fsm_in_nxt = r_mem[r_rd_ptr];
                    w_strobe_nxt = 1'b1;
                    w_hold_nxt   = c_hold_load;
                    w_state_nxt  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt != '0) begin
                    w_hold_nxt = r_hold_cnt - 1'b1;
                end else if (w_not_empty) begin
                    w_pop        = 1'b1;
                    w_fsm_in_nxt = r_mem[r_rd_ptr];
                    w_strobe_nxt = 1'b1;
                    w_hold_nxt   = c_hold_load;
                end else begin
                    w_fsm_in_nxt = IDLE_CODE;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_fsm_in_nxt = IDLE_CODE;
                w_state_nxt  = ST_IDLE;
            end
        endcase

        if (bus.flush) begin
            w_pop        = 1'b0;
            w_state_nxt  = ST_IDLE;
            w_fsm_in_nxt = IDLE_CODE;
            w_strobe_nxt = 1'b0;
            w_hold_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_fsm_in   <= IDLE_CODE;
            r_strobe   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_fsm_in   <= w_fsm_in_nxt;
            r_strobe   <= w_strobe_nxt;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.cmd_data;
        end
    end

`ifdef FSM_CMD_FEEDER_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    // Counts refused offers; a flush cycle clears rather than counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (bus.flush) begin
            r_drop_cnt <= '0;
        end else if (bus.cmd_valid && !w_ready && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_count = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fsm_cmd_feeder.sv
// ============================================================================
// Module   : tb_fsm_cmd_feeder
// Brief    : Directed + randomized bench for fsm_cmd_feeder against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_cmd_feeder;

    localparam int         DEPTH = 4;
    localparam int         HOLD  = 3;
    localparam logic [1:0] IDLE  = 2'h3;

    logic clk;
    logic rst_n;

    fsm_cmd_feeder_if #(.DEPTH(DEPTH)) bus ();

`ifdef FSM_CMD_FEEDER_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    fsm_cmd_feeder #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .IDLE_CODE   (IDLE)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave)
`ifdef FSM_CMD_FEEDER_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending commands, code on display and cycles left.
    logic [1:0] m_q [$];
    logic [1:0] m_code;
    int         m_left;
    bit         m_strobe;
    int         m_drops;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_code   = IDLE;
        m_left   = 0;
        m_strobe = 1'b0;
        m_drops  = 0;
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".fsm_in"}, 32'(bus.fsm_in), 32'(m_code));
        check_val({tag, ".strobe"}, 32'(bus.fsm_cmd_strobe), 32'(m_strobe));
        check_val({tag, ".count"}, 32'(bus.count), 32'(m_q.size()));
        check_val({tag, ".busy"}, 32'(bus.busy), 32'((m_left != 0) || (m_q.size() != 0)));
        check_val({tag, ".ready"}, 32'(bus.cmd_ready), 32'(m_q.size() != DEPTH));
`ifdef FSM_CMD_FEEDER_DROP_CNT_EN
        check_val({tag, ".drops"}, 32'(drop_count), 32'(m_drops));
`endif
    endtask

    // Called at a negedge: drive, advance one edge, update model, compare.
    task automatic step(input bit v, input logic [1:0] d, input bit f, input string tag);
        bit rdy_pre;
        bus.cmd_valid = v;
        bus.cmd_data  = d;
        bus.flush     = f;
        @(posedge clk);
        rdy_pre = (m_q.size() != DEPTH);
        if (f) begin
            m_q.delete();
            m_left   = 0;
            m_code   = IDLE;
            m_strobe = 1'b0;
            m_drops  = 0;
        end else begin
            if (v && !rdy_pre && m_drops < 255) m_drops++;
            if (m_left > 1) begin
                m_left--;
                m_strobe = 1'b0;
            end else if (m_q.size() != 0) begin
                m_code   = m_q.pop_front();
                m_left   = HOLD;
                m_strobe = 1'b1;
            end else begin
                m_left   = 0;
                m_code   = IDLE;
                m_strobe = 1'b0;
            end
            if (v && rdy_pre) m_q.push_back(d);
        end
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 2'h0;
        bus.flush     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    logic [1:0] exp_b2b [10] = '{2'h1, 2'h1, 2'h1, 2'h0, 2'h0, 2'h0, 2'h1, 2'h1, 2'h1, 2'h3};
    bit         exp_stb [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] seen [$];
    logic [1:0] b2b_cmd [3] = '{2'h1, 2'h0, 2'h1};

    initial begin
        model_reset();
        do_reset();
        compare_all("reset");

        // Back-to-back: 1,0,1 on consecutive edges.
        for (int i = 0; i < 3; i++) step(1'b1, b2b_cmd[i], 1'b0, "b2b_push");
        for (int i = 0; i < 8; i++) step(1'b0, 2'h0, 1'b0, "b2b_idle");
        // The 11 steps above covered edges 0..10; re-run for a fixed-pattern view.
        repeat (4) step(1'b0, 2'h0, 1'b0, "drain");
        for (int i = 0; i < 11; i++) begin
            step((i < 3), (i < 3) ? b2b_cmd[i] : 2'h0, 1'b0, "b2b2");
            if (i >= 1) begin
                check_val($sformatf("b2b_seq[%0d]", i - 1), 32'(bus.fsm_in), 32'(exp_b2b[i - 1]));
                check_val($sformatf("b2b_stb[%0d]", i - 1), 32'(bus.fsm_cmd_strobe), 32'(exp_stb[i - 1]));
            end
        end
        repeat (4) step(1'b0, 2'h0, 1'b0, "drain");

        // Full FIFO: seventh consecutive offer is refused.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 2'(i % 4), 1'b0, "full_push");
            if (i == 5) check_val("full_ready_low", 32'(bus.cmd_ready), 32'd0);
            if (i == 5) check_val("full_count", 32'(bus.count), 32'(DEPTH));
        end
`ifdef FSM_CMD_FEEDER_DROP_CNT_EN
        check_val("full_drop_one", 32'(drop_count), 32'd1);
`endif
        repeat (30) step(1'b0, 2'h0, 1'b0, "full_drain");

        // Flush with a concurrent push while HOLD is active and count=3.
        for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 1'b0, "flush_fill");
        check_val("flush_pre_count", 32'(bus.count), 32'd3);
        step(1'b1, 2'h2, 1'b1, "flush");
        check_val("flush_count", 32'(bus.count), 32'd0);
        check_val("flush_fsm_in", 32'(bus.fsm_in), 32'(IDLE));
        check_val("flush_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (5) step(1'b0, 2'h0, 1'b0, "post_flush");

        // Wrap-around: 10 commands paced to the drain rate, order preserved.
        seen.delete();
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < HOLD; j++) begin
                step((j == 0), (j == 0) ? 2'(i % 4) : 2'h0, 1'b0, "wrap");
                if (bus.fsm_cmd_strobe) seen.push_back(bus.fsm_in);
                check_val("wrap_cnt_le_depth", 32'(bus.count <= DEPTH), 32'd1);
            end
        end
        repeat (6) begin
            step(1'b0, 2'h0, 1'b0, "wrap_drain");
            if (bus.fsm_cmd_strobe) seen.push_back(bus.fsm_in);
        end
        check_val("wrap_n_seen", 32'(seen.size()), 32'd10);
        for (int i = 0; i < 10 && i < seen.size(); i++)
            check_val($sformatf("wrap_order[%0d]", i), 32'(seen[i]), 32'(i % 4));

        // Asynchronous reset in the middle of a hold of code 1.
        step(1'b1, 2'h1, 1'b0, "ar_push");
        step(1'b0, 2'h0, 1'b0, "ar_hold");
        check_val("ar_pre_fsm_in", 32'(bus.fsm_in), 32'h1);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 2'h2;
        #2 rst_n = 1'b0;
        #1;
        check_val("ar_fsm_in", 32'(bus.fsm_in), 32'(IDLE));
        check_val("ar_count", 32'(bus.count), 32'd0);
        check_val("ar_busy", 32'(bus.busy), 32'd0);
        check_val("ar_ready", 32'(bus.cmd_ready), 32'd1);
        check_val("ar_strobe", 32'(bus.fsm_cmd_strobe), 32'd0);
        @(negedge clk);
        check_val("ar_hold_ready", 32'(bus.cmd_ready), 32'd1);
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 2'h0, 1'b0, "ar_after");

        // Randomized traffic with varying offer density and rare flushes.
        for (int i = 0; i < 600; i++) begin
            int  pct;
            bit  v;
            bit  f;
            pct = (i < 200) ? 30 : ((i < 400) ? 90 : 60);
            v   = ($urandom_range(99) < pct);
            f   = ($urandom_range(39) == 0);
            step(v, 2'($urandom_range(3)), f, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
